// File: rtl/dff_sync_reset_pipe.sv
// DEPTH-stage valid/ready register pipeline: DEPTH-cycle latency, bubbles collapse under stall,
// combinational ready chain for backpressure; `PIPE_FLUSH_EN adds a flush port that empties every stage.
module dff_sync_reset_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             r_n,
`ifdef PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNTW-1:0]  occupancy
);

  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d;
  logic [CNTW-1:0]             occ_q, occ_d;
  logic [DEPTH-1:0]            rdy;
  logic                        flush_w;
  logic                        in_hs;
  logic                        out_hs;

`ifdef PIPE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // A stage is ready if it is empty or anything downstream of it can move.
  always_comb begin
    logic acc;
    rdy = '0;
    acc = out_ready | ~v_q[DEPTH-1];
    rdy[DEPTH-1] = acc;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      acc    = acc | ~v_q[i];
      rdy[i] = acc;
    end
  end

  assign in_ready  = rdy[0] & ~flush_w;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;
  assign in_hs     = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready & ~flush_w;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (rdy[0]) begin
      v_d[0] = in_valid;
      if (in_valid) d_d[0] = in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (rdy[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) d_d[i] = d_q[i-1];
      end
    end
    occ_d = occ_q + CNTW'(in_hs) - CNTW'(out_hs);
  end

  always_ff @(posedge clk) begin
    if (!r_n) begin
      v_q   <= '0;
      d_q   <= '0;
      occ_q <= '0;
    end else if (flush_w) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_dff_sync_reset_pipe.sv
// Bench for dff_sync_reset_pipe (WIDTH=8, DEPTH=4): directed scenarios plus random traffic
// against a queue model where each word's stage is tracked as a position capped by its queue rank.
module tb_dff_sync_reset_pipe;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH + 1);
  localparam int EW    = 2 + WIDTH + CNTW;

  logic             clk = 1'b0;
  logic             r_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b1;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic [CNTW-1:0]  occupancy;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] m_dat[$];
  int               m_pos[$];
  logic [WIDTH-1:0] m_last = '0;

  dff_sync_reset_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .r_n       (r_n),
`ifdef PIPE_FLUSH_EN
    .flush     (flush),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic m_ir();
    return out_ready || (m_dat.size() < DEPTH);
  endfunction

  function automatic logic m_ov();
    return (m_dat.size() > 0) && (m_pos[0] == DEPTH - 1);
  endfunction

  function automatic logic [EW-1:0] m_exp();
    return {m_ir(), m_ov(), m_last, CNTW'(m_dat.size())};
  endfunction

  // Drive inputs just after the falling edge; outputs are then settled for sampling.
  task automatic set_in(input logic iv, input logic [WIDTH-1:0] id, input logic ordy, input logic rn);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    r_n       = rn;
    #1;
  endtask

  // Advance the model by one edge from the current inputs, then let the DUT take that edge.
  task automatic tick();
    logic ir, ohs, ihs;
    int   np;
    if (!r_n) begin
      m_dat.delete(); m_pos.delete(); m_last = '0;
    end else if (flush) begin
      m_dat.delete(); m_pos.delete();
    end else begin
      ir  = m_ir();
      ohs = m_ov() && out_ready;
      ihs = in_valid && ir;
      if (ohs) begin
        void'(m_dat.pop_front());
        void'(m_pos.pop_front());
      end
      for (int k = 0; k < m_dat.size(); k++) begin
        np = (m_pos[k] + 1 < DEPTH - 1 - k) ? m_pos[k] + 1 : DEPTH - 1 - k;
        if (np == DEPTH - 1 && m_pos[k] != DEPTH - 1) m_last = m_dat[k];
        m_pos[k] = np;
      end
      if (ihs) begin
        m_dat.push_back(in_data);
        m_pos.push_back(0);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    set_in(1'b1, 8'h55, 1'b1, 1'b0); tick();
    set_in(1'b1, 8'h66, 1'b1, 1'b0); tick();
    set_in(1'b0, 8'h00, 1'b1, 1'b1);
    total++;
    if ({in_ready, out_valid, out_data, occupancy} !== {1'b1, 1'b0, 8'h00, 3'd0}) begin
      bad++;
      $display("FAIL reset rdy/vld/dat/occ got %b/%b/%h/%0d want 1/0/00/0", in_ready, out_valid, out_data, occupancy);
    end
    tick();
  endtask

  task automatic test_stream();
    int n = 1, acc_c = -1, first_c = -1;
    logic [WIDTH-1:0] got[$];
    for (int c = 0; c < 30; c++) begin
      set_in(n <= 16, WIDTH'(n), 1'b1, 1'b1);
      total++;
      if ({in_ready, out_valid, out_data, occupancy} !== m_exp()) begin
        bad++;
        $display("FAIL stream c=%0d rdy/vld/dat/occ got %h want %h", c, {in_ready, out_valid, out_data, occupancy}, m_exp());
      end
      if (c == 8) begin
        total++;
        if (occupancy !== 3'd4) begin bad++; $display("FAIL stream_occ got %0d want 4", occupancy); end
      end
      if (out_valid && first_c < 0) first_c = c;
      if (out_valid) got.push_back(out_data);
      if (in_valid && in_ready) begin
        if (acc_c < 0) acc_c = c;
        n++;
      end
      tick();
    end
    total++;
    if (first_c - acc_c !== 4) begin bad++; $display("FAIL stream_latency got %0d want 4", first_c - acc_c); end
    total++;
    if (got.size() !== 16) begin bad++; $display("FAIL stream_count got %0d want 16", got.size()); end
    for (int i = 0; i < got.size() && i < 16; i++) begin
      total++;
      if (got[i] !== WIDTH'(i + 1)) begin bad++; $display("FAIL stream_order i=%0d got %h want %h", i, got[i], i + 1); end
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    logic [WIDTH-1:0] got[$];
    for (int c = 0; c < 10; c++) begin
      set_in(k < 6, WIDTH'(8'h30 + k), 1'b0, 1'b1);
      total++;
      if ({in_ready, out_valid, out_data, occupancy} !== m_exp()) begin
        bad++;
        $display("FAIL bp_fill c=%0d got %h want %h", c, {in_ready, out_valid, out_data, occupancy}, m_exp());
      end
      if (in_valid && in_ready) k++;
      tick();
    end
    set_in(1'b1, WIDTH'(8'h30 + k), 1'b0, 1'b1);
    total++;
    if ({k[3:0], in_ready, occupancy, out_data} !== {4'd4, 1'b0, 3'd4, 8'h30}) begin
      bad++;
      $display("FAIL bp_full acc/rdy/occ/dat got %0d/%b/%0d/%h want 4/0/4/30", k, in_ready, occupancy, out_data);
    end
    tick();
    for (int c = 0; c < 12; c++) begin
      set_in(k < 6, WIDTH'(8'h30 + k), 1'b1, 1'b1);
      total++;
      if ({in_ready, out_valid, out_data, occupancy} !== m_exp()) begin
        bad++;
        $display("FAIL bp_drain c=%0d got %h want %h", c, {in_ready, out_valid, out_data, occupancy}, m_exp());
      end
      if (c == 1) begin
        total++;
        if (occupancy !== 3'd4) begin bad++; $display("FAIL bp_both_hs occ got %0d want 4", occupancy); end
      end
      if (out_valid) got.push_back(out_data);
      if (in_valid && in_ready) k++;
      tick();
    end
    total++;
    if (got.size() !== 6) begin bad++; $display("FAIL bp_count got %0d want 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      total++;
      if (got[i] !== WIDTH'(8'h30 + i)) begin bad++; $display("FAIL bp_order i=%0d got %h want %h", i, got[i], 8'h30 + i); end
    end
  endtask

  task automatic test_bubble();
    set_in(1'b1, 8'hA1, 1'b0, 1'b1); tick();
    set_in(1'b0, 8'hEE, 1'b0, 1'b1); tick();
    set_in(1'b0, 8'hEE, 1'b0, 1'b1); tick();
    set_in(1'b1, 8'hA2, 1'b0, 1'b1); tick();
    for (int c = 0; c < 4; c++) begin set_in(1'b0, 8'hEE, 1'b0, 1'b1); tick(); end
    set_in(1'b0, 8'hEE, 1'b0, 1'b1);
    total++;
    if ({occupancy, in_ready, out_valid, out_data} !== {3'd2, 1'b1, 1'b1, 8'hA1}) begin
      bad++;
      $display("FAIL bubble occ/rdy/vld/dat got %0d/%b/%b/%h want 2/1/1/a1", occupancy, in_ready, out_valid, out_data);
    end
    tick();
    set_in(1'b0, 8'hEE, 1'b1, 1'b1); tick();
    set_in(1'b0, 8'hEE, 1'b1, 1'b1);
    total++;
    if ({out_valid, out_data} !== {1'b1, 8'hA2}) begin
      bad++;
      $display("FAIL bubble_adjacent vld/dat got %b/%h want 1/a2", out_valid, out_data);
    end
    tick();
    for (int c = 0; c < 3; c++) begin set_in(1'b0, 8'hEE, 1'b1, 1'b1); tick(); end
  endtask

  task automatic test_midreset();
    for (int c = 0; c < 3; c++) begin set_in(1'b1, WIDTH'(8'h70 + c), 1'b0, 1'b1); tick(); end
    set_in(1'b0, 8'hEE, 1'b0, 1'b1);
    total++;
    if (occupancy !== 3'd3) begin bad++; $display("FAIL midrst_pre occ got %0d want 3", occupancy); end
    tick();
    set_in(1'b1, 8'h77, 1'b1, 1'b0); tick();
    set_in(1'b0, 8'hEE, 1'b0, 1'b1);
    total++;
    if ({occupancy, out_valid, out_data, in_ready} !== {3'd0, 1'b0, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL midrst occ/vld/dat/rdy got %0d/%b/%h/%b want 0/0/00/1", occupancy, out_valid, out_data, in_ready);
    end
    tick();
  endtask

`ifdef PIPE_FLUSH_EN
  task automatic test_flush();
    for (int c = 0; c < 6; c++) begin set_in(1'b1, WIDTH'(8'h90 + c), 1'b0, 1'b1); tick(); end
    set_in(1'b1, 8'h99, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    total++;
    if ({occupancy, in_ready} !== {3'd4, 1'b0}) begin
      bad++;
      $display("FAIL flush_pre occ/rdy got %0d/%b want 4/0", occupancy, in_ready);
    end
    tick();
    set_in(1'b0, 8'hEE, 1'b0, 1'b1);
    flush = 1'b0;
    #1;
    total++;
    if ({occupancy, out_valid} !== {3'd0, 1'b0}) begin
      bad++;
      $display("FAIL flush occ/vld got %0d/%b want 0/0", occupancy, out_valid);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_in(1'($urandom_range(0, 1)), WIDTH'($urandom), $urandom_range(0, 3) != 0, 1'b1);
      total++;
      if ({in_ready, out_valid, out_data, occupancy} !== m_exp()) begin
        bad++;
        $display("FAIL random c=%0d got %h want %h", c, {in_ready, out_valid, out_data, occupancy}, m_exp());
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_bubble();
    test_midreset();
`ifdef PIPE_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
